// File: rtl/ir_sched_pkg.sv
// Shared types and constants for the IR transmitter command scheduler.
package ir_sched_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_COLOUR = 2'd1,
        ST_WR_CMD    = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    typedef struct packed {
        logic [NIB_W-1:0] colour;
        logic [NIB_W-1:0] cmd;
    } ir_req_t;

    typedef struct packed {
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } bus_wr_t;

    localparam logic [NIB_W-1:0]  CMD_STOP          = 4'h0;
    localparam logic [BYTE_W-1:0] COLOUR_REG_OFFSET = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_REG_OFFSET    = 8'h00;

    // Zero-extend a register nibble to a bus data byte.
    function automatic logic [BYTE_W-1:0] nibble_to_byte(input logic [NIB_W-1:0] n);
        return {{(BYTE_W-NIB_W){1'b0}}, n};
    endfunction

endpackage

// File: rtl/ir_rr_arbiter.sv
// Two-requester round-robin arbiter; the requester not served last wins a tie.
module ir_rr_arbiter
    import ir_sched_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic a_valid,
    input  logic b_valid,
    input  logic accept,
    output logic grant_a,
    output logic grant_b
);

    grant_t last_grant;
    logic   xfer;

    assign grant_a = a_valid & (~b_valid | (last_grant == GRANT_B));
    assign grant_b = b_valid & (~a_valid | (last_grant == GRANT_A));
    assign xfer    = accept & (grant_a | grant_b);

    // Reset to B so that A takes the first tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GRANT_B;
        end else if (xfer) begin
            last_grant <= grant_a ? GRANT_A : GRANT_B;
        end
    end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Shares the IR transmitter between two requesters: colour/command bus writes,
// packet-based hold, and auto-STOP on idle. Optional macro: IR_SCHED_STATS_EN.
module ir_cmd_scheduler
    import ir_sched_pkg::*;
#(
    parameter logic [7:0]  IR_BASE_ADDR      = 8'h90,
    parameter int unsigned HOLD_PACKETS      = 4,
    parameter int unsigned IDLE_TIMEOUT_PKTS = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PACKET_TICK,
    input  logic        A_VALID,
    input  logic [3:0]  A_COLOUR,
    input  logic [3:0]  A_CMD,
    output logic        A_READY,
    input  logic        B_VALID,
    input  logic [3:0]  B_COLOUR,
    input  logic [3:0]  B_CMD,
    output logic        B_READY,
    output logic [7:0]  BUS_ADDR,
    output logic [7:0]  BUS_DATA,
    output logic        BUS_WE,
    output logic        BUSY,
    output logic [15:0] CMD_COUNT
);

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_PACKETS);
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(IDLE_TIMEOUT_PKTS);

    state_t            state, state_n;
    bus_wr_t           bus_q, bus_n;
    logic              we_q, we_n;
    logic              busy_q;
    ir_req_t           last_q, last_n;
    logic              colour_valid_q, colour_valid_n;
    logic [CNT_W-1:0]  hold_cnt, hold_n;
    logic [CNT_W-1:0]  idle_cnt, idle_n;
    logic              stop_q, stop_n;
    logic              accept, grant_a, grant_b, xfer;
    ir_req_t           sel;

    ir_rr_arbiter u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .a_valid (A_VALID),
        .b_valid (B_VALID),
        .accept  (accept),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign accept  = (state == ST_IDLE) || ((state == ST_HOLD) && (hold_cnt == '0));
    assign A_READY = grant_a & accept;
    assign B_READY = grant_b & accept;
    assign xfer    = A_READY | B_READY;
    assign sel     = A_READY ? {A_COLOUR, A_CMD} : {B_COLOUR, B_CMD};

    // Next-state and registered-output decode; a new transfer outranks the idle timeout.
    always_comb begin
        state_n        = state;
        bus_n          = bus_q;
        we_n           = 1'b0;
        last_n         = last_q;
        colour_valid_n = colour_valid_q;
        hold_n         = hold_cnt;
        idle_n         = idle_cnt;
        stop_n         = stop_q;

        if (xfer) begin
            last_n         = sel;
            colour_valid_n = 1'b1;
            stop_n         = 1'b0;
            we_n           = 1'b1;
            if (!colour_valid_q || (sel.colour != last_q.colour)) begin
                state_n    = ST_WR_COLOUR;
                bus_n.addr = IR_BASE_ADDR + COLOUR_REG_OFFSET;
                bus_n.data = nibble_to_byte(sel.colour);
            end else begin
                state_n    = ST_WR_CMD;
                bus_n.addr = IR_BASE_ADDR + CMD_REG_OFFSET;
                bus_n.data = nibble_to_byte(sel.cmd);
            end
        end else begin
            unique case (state)
                ST_IDLE: state_n = ST_IDLE;
                ST_WR_COLOUR: begin
                    state_n    = ST_WR_CMD;
                    we_n       = 1'b1;
                    bus_n.addr = IR_BASE_ADDR + CMD_REG_OFFSET;
                    bus_n.data = nibble_to_byte(last_q.cmd);
                end
                ST_WR_CMD: begin
                    stop_n = 1'b0;
                    if (stop_q) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_HOLD;
                        hold_n  = HOLD_INIT;
                        idle_n  = '0;
                    end
                end
                ST_HOLD: begin
                    if (PACKET_TICK) begin
                        if (hold_cnt != '0) begin
                            hold_n = hold_cnt - CNT_W'(1);
                        end else if (TIMEOUT != '0) begin
                            if ((idle_cnt + CNT_W'(1)) == TIMEOUT) begin
                                if (last_q.cmd != CMD_STOP) begin
                                    state_n    = ST_WR_CMD;
                                    we_n       = 1'b1;
                                    bus_n.addr = IR_BASE_ADDR + CMD_REG_OFFSET;
                                    bus_n.data = nibble_to_byte(CMD_STOP);
                                    last_n.cmd = CMD_STOP;
                                    stop_n     = 1'b1;
                                end else begin
                                    state_n = ST_IDLE;
                                end
                            end else begin
                                idle_n = idle_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            bus_q          <= '0;
            we_q           <= 1'b0;
            busy_q         <= 1'b0;
            last_q         <= '0;
            colour_valid_q <= 1'b0;
            hold_cnt       <= '0;
            idle_cnt       <= '0;
            stop_q         <= 1'b0;
        end else begin
            state          <= state_n;
            bus_q          <= bus_n;
            we_q           <= we_n;
            busy_q         <= (state_n != ST_IDLE);
            last_q         <= last_n;
            colour_valid_q <= colour_valid_n;
            hold_cnt       <= hold_n;
            idle_cnt       <= idle_n;
            stop_q         <= stop_n;
        end
    end

    assign BUS_ADDR = bus_q.addr;
    assign BUS_DATA = bus_q.data;
    assign BUS_WE   = we_q;
    assign BUSY     = busy_q;

`ifdef IR_SCHED_STATS_EN
    logic [STAT_W-1:0] cmd_count;

    // Saturating count of command-register writes, auto-STOP included.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_count <= '0;
        end else if ((state == ST_WR_CMD) && (cmd_count != '1)) begin
            cmd_count <= cmd_count + STAT_W'(1);
        end
    end

    assign CMD_COUNT = cmd_count;
`else
    assign CMD_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed bench for ir_cmd_scheduler: per-cycle vector table plus hold/timeout sequences.
module tb_ir_cmd_scheduler;

`ifdef IR_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PACKET_TICK = 1'b0;
    logic        A_VALID = 1'b0;
    logic [3:0]  A_COLOUR = 4'h0;
    logic [3:0]  A_CMD = 4'h0;
    logic        A_READY;
    logic        B_VALID = 1'b0;
    logic [3:0]  B_COLOUR = 4'h0;
    logic [3:0]  B_CMD = 4'h0;
    logic        B_READY;
    logic [7:0]  BUS_ADDR;
    logic [7:0]  BUS_DATA;
    logic        BUS_WE;
    logic        BUSY;
    logic [15:0] CMD_COUNT;

    int errors = 0;
    int checks = 0;

    ir_cmd_scheduler dut (
        .CLK         (CLK),
        .RST         (RST),
        .PACKET_TICK (PACKET_TICK),
        .A_VALID     (A_VALID),
        .A_COLOUR    (A_COLOUR),
        .A_CMD       (A_CMD),
        .A_READY     (A_READY),
        .B_VALID     (B_VALID),
        .B_COLOUR    (B_COLOUR),
        .B_CMD       (B_CMD),
        .B_READY     (B_READY),
        .BUS_ADDR    (BUS_ADDR),
        .BUS_DATA    (BUS_DATA),
        .BUS_WE      (BUS_WE),
        .BUSY        (BUSY),
        .CMD_COUNT   (CMD_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       av;
        logic [3:0] ac;
        logic [3:0] acmd;
        logic       bv;
        logic [3:0] bc;
        logic [3:0] bcmd;
        logic       tk;
        logic       ar;
        logic       br;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] wlog[$];

    // Record every bus write as {addr, data}.
    always @(negedge CLK) begin
        if (BUS_WE === 1'b1) wlog.push_back({BUS_ADDR, BUS_DATA});
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void add(input int rst, input int av, input int ac, input int acmd,
                                input int bv, input int bc, input int bcmd, input int tk,
                                input int ar, input int br, input int we, input int addr,
                                input int data, input int busy);
        vec_t v;
        v.rst = 1'(rst);  v.av = 1'(av);   v.ac = 4'(ac);     v.acmd = 4'(acmd);
        v.bv = 1'(bv);    v.bc = 4'(bc);   v.bcmd = 4'(bcmd); v.tk = 1'(tk);
        v.ar = 1'(ar);    v.br = 1'(br);   v.we = 1'(we);     v.addr = 8'(addr);
        v.data = 8'(data); v.busy = 1'(busy);
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        repeat (2) begin
            @(negedge CLK);
            RST = 1'b1; PACKET_TICK = 1'b0;
            A_VALID = 1'b0; A_COLOUR = 4'h0; A_CMD = 4'h0;
            B_VALID = 1'b0; B_COLOUR = 4'h0; B_CMD = 4'h0;
        end
    endtask

    // One cycle of requester-A stimulus, optionally checking A_READY.
    task automatic cyc(input int av, input int ac, input int acmd, input int tk,
                       input bit chk_rdy, input int exp_rdy, input string nm);
        @(negedge CLK);
        RST = 1'b0; B_VALID = 1'b0;
        A_VALID = 1'(av); A_COLOUR = 4'(ac); A_CMD = 4'(acmd); PACKET_TICK = 1'(tk);
        #1;
        if (chk_rdy) check(nm, 32'(A_READY), 32'(exp_rdy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst av ac acmd bv bc bcmd tk | ar br we addr data busy
        add(0, 1, 2, 5, 0, 0, 0, 0,  1, 0, 0, 'h00, 'h00, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h91, 'h02, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h90, 'h05, 1);
        repeat (4) add(0, 1, 2, 6, 0, 0, 0, 1,  0, 0, 0, 'h90, 'h05, 1);
        add(0, 1, 2, 6, 0, 0, 0, 0,  1, 0, 0, 'h90, 'h05, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h90, 'h06, 1);
        repeat (4) add(0, 1, 2, 7, 1, 3, 9, 1,  0, 0, 0, 'h90, 'h06, 1);
        add(0, 1, 2, 7, 1, 3, 9, 0,  0, 1, 0, 'h90, 'h06, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h91, 'h03, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h90, 'h09, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h90, 'h09, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h90, 'h09, 1);
        add(0, 1, 1, 5, 1, 4, 3, 0,  1, 0, 0, 'h00, 'h00, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h91, 'h01, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h00, 'h00, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h00, 'h00, 0);

        do_reset();
        @(negedge CLK);
        #1;
        check("reset cmd_count", 32'(CMD_COUNT), 32'(0));

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst;
            A_VALID = vecs[i].av; A_COLOUR = vecs[i].ac; A_CMD = vecs[i].acmd;
            B_VALID = vecs[i].bv; B_COLOUR = vecs[i].bc; B_CMD = vecs[i].bcmd;
            PACKET_TICK = vecs[i].tk;
            #1;
            check($sformatf("v%0d a_ready", i),  32'(A_READY),  32'(vecs[i].ar));
            check($sformatf("v%0d b_ready", i),  32'(B_READY),  32'(vecs[i].br));
            check($sformatf("v%0d bus_we", i),   32'(BUS_WE),   32'(vecs[i].we));
            check($sformatf("v%0d bus_addr", i), 32'(BUS_ADDR), 32'(vecs[i].addr));
            check($sformatf("v%0d bus_data", i), 32'(BUS_DATA), 32'(vecs[i].data));
            check($sformatf("v%0d busy", i),     32'(BUSY),     32'(vecs[i].busy));
        end

        // Hold counting ignores ticks during writes; then idle timeout issues STOP.
        do_reset();
        wlog.delete();
        cyc(1, 2, 5, 0, 1, 1, "seq a_ready first");
        cyc(0, 0, 0, 1, 0, 0, "");
        cyc(0, 0, 0, 1, 0, 0, "");
        repeat (3) cyc(0, 0, 0, 1, 0, 0, "");
        cyc(1, 2, 3, 0, 1, 0, "seq a_ready during hold");
        cyc(0, 0, 0, 1, 0, 0, "");
        cyc(1, 2, 3, 0, 1, 1, "seq a_ready at hold expiry");
        cyc(0, 0, 0, 1, 0, 0, "");
        repeat (23) cyc(0, 0, 0, 1, 0, 0, "");
        check("seq writes before timeout", 32'(wlog.size()), 32'(3));
        if (wlog.size() == 3) begin
            check("seq wr0", 32'(wlog[0]), 32'h9102);
            check("seq wr1", 32'(wlog[1]), 32'h9005);
            check("seq wr2 same colour", 32'(wlog[2]), 32'h9003);
        end
        check("seq busy before timeout", 32'(BUSY), 32'(1));
        cyc(0, 0, 0, 1, 0, 0, "");
        cyc(0, 0, 0, 0, 0, 0, "");
        check("stop we", 32'(BUS_WE), 32'(1));
        check("stop addr", 32'(BUS_ADDR), 32'h90);
        check("stop data", 32'(BUS_DATA), 32'h00);
        cyc(0, 0, 0, 0, 0, 0, "");
        check("stop then idle busy", 32'(BUSY), 32'(0));
        check("stop then idle we", 32'(BUS_WE), 32'(0));
        check("cmd_count after stop", 32'(CMD_COUNT), STATS ? 32'(3) : 32'(0));
        repeat (25) cyc(0, 0, 0, 1, 0, 0, "");
        check("no writes from idle", 32'(wlog.size()), 32'(4));
        check("idle busy", 32'(BUSY), 32'(0));

        // Timeout with last command already STOP returns to IDLE without a write.
        cyc(1, 2, 0, 0, 1, 1, "stop cmd a_ready");
        cyc(0, 0, 0, 0, 0, 0, "");
        check("stop cmd we", 32'(BUS_WE), 32'(1));
        check("stop cmd addr", 32'(BUS_ADDR), 32'h90);
        repeat (24) cyc(0, 0, 0, 1, 0, 0, "");
        cyc(0, 0, 0, 0, 0, 0, "");
        cyc(0, 0, 0, 0, 0, 0, "");
        check("silent timeout busy", 32'(BUSY), 32'(0));
        check("silent timeout writes", 32'(wlog.size()), 32'(5));
        check("cmd_count total", 32'(CMD_COUNT), STATS ? 32'(4) : 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
